// File: rtl/sdram_arbiter.sv
// Two-port arbiter and single-word transaction sequencer for the SDRAM controller host port.
// Define SDRAM_ARB_APRIO_EN to give port A strict priority instead of round-robin.
module sdram_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_req,
    input  logic        a_wr,
    input  logic [22:0] a_addr,
    input  logic [15:0] a_wr_data,
    output logic        a_ack,
    output logic [15:0] a_rd_data,
    input  logic        b_req,
    input  logic        b_wr,
    input  logic [22:0] b_addr,
    input  logic [15:0] b_wr_data,
    output logic        b_ack,
    output logic [15:0] b_rd_data,
    output logic        err,
    output logic [22:0] h_addr,
    output logic [15:0] h_wr_data,
    output logic        h_en,
    output logic        h_rd,
    output logic        h_wr,
    input  logic [15:0] h_data_rd,
    input  logic        h_done,
    output logic        h_idle
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

    localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

    state_e      state;
    logic        grant_b;
    logic        last_b;
    logic [7:0]  cnt;
    logic [7:0]  cnt_inc;
    logic        a_wins;
    logic        finish;
    logic [15:0] rd_value;

`ifdef SDRAM_ARB_APRIO_EN
    assign a_wins = a_req;
`else
    // last_b set means B was served last, so A takes the tie.
    assign a_wins = a_req & (~b_req | last_b);
`endif

    assign cnt_inc  = cnt + 8'd1;
    assign finish   = h_done | (cnt_inc == TimeoutCnt);
    assign rd_value = h_done ? h_data_rd : 16'hFFFF;
    assign h_idle   = (state == StIdle) & ~a_req & ~b_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            grant_b   <= 1'b0;
            last_b    <= 1'b1;
            cnt       <= 8'd0;
            a_ack     <= 1'b0;
            b_ack     <= 1'b0;
            err       <= 1'b0;
            a_rd_data <= 16'd0;
            b_rd_data <= 16'd0;
            h_addr    <= 23'd0;
            h_wr_data <= 16'd0;
            h_en      <= 1'b0;
            h_rd      <= 1'b0;
            h_wr      <= 1'b0;
        end else begin
            a_ack <= 1'b0;
            b_ack <= 1'b0;
            err   <= 1'b0;
            case (state)
                StIdle: begin
                    if (a_req | b_req) begin
                        grant_b   <= ~a_wins;
                        h_addr    <= a_wins ? a_addr : b_addr;
                        h_wr_data <= a_wins ? a_wr_data : b_wr_data;
                        h_rd      <= a_wins ? ~a_wr : ~b_wr;
                        h_wr      <= a_wins ? a_wr : b_wr;
                        h_en      <= 1'b1;
                        state     <= StIssue;
                    end
                end
                StIssue: begin
                    h_en  <= 1'b0;
                    cnt   <= 8'd0;
                    state <= StWait;
                end
                StWait: begin
                    cnt <= cnt_inc;
                    if (finish) begin
                        // A completion coinciding with the timeout still counts as success.
                        err <= ~h_done;
                        if (grant_b) begin
                            b_ack <= 1'b1;
                            if (h_rd) b_rd_data <= rd_value;
                        end else begin
                            a_ack <= 1'b1;
                            if (h_rd) a_rd_data <= rd_value;
                        end
                        last_b <= grant_b;
                        h_rd   <= 1'b0;
                        h_wr   <= 1'b0;
                        state  <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: vector table driven through a scoreboard plus
// hand-written reset and stray-completion sequences.
module tb_sdram_arbiter;

    localparam int T = 20;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_req, a_wr, b_req, b_wr;
    logic [22:0] a_addr, b_addr;
    logic [15:0] a_wr_data, b_wr_data;
    logic        a_ack, b_ack, err;
    logic [15:0] a_rd_data, b_rd_data;
    logic [22:0] h_addr;
    logic [15:0] h_wr_data, h_data_rd;
    logic        h_en, h_rd, h_wr, h_done, h_idle;

    sdram_arbiter #(.TIMEOUT(T)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_wr(a_wr), .a_addr(a_addr), .a_wr_data(a_wr_data),
        .a_ack(a_ack), .a_rd_data(a_rd_data),
        .b_req(b_req), .b_wr(b_wr), .b_addr(b_addr), .b_wr_data(b_wr_data),
        .b_ack(b_ack), .b_rd_data(b_rd_data),
        .err(err), .h_addr(h_addr), .h_wr_data(h_wr_data), .h_en(h_en),
        .h_rd(h_rd), .h_wr(h_wr), .h_data_rd(h_data_rd), .h_done(h_done),
        .h_idle(h_idle)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          a_req;
        bit          b_req;
        bit          a_wr;
        bit          b_wr;
        logic [22:0] a_addr;
        logic [22:0] b_addr;
        logic [15:0] a_wd;
        logic [15:0] b_wd;
        int          dly;   // WAIT cycles before HDone minus one; -1 means never
        logic [15:0] rd;
    } vec_t;

    typedef struct {
        bit          port_b;
        bit          err;
        logic [15:0] ra;
        logic [15:0] rb;
    } exp_t;

    exp_t        sb[$];
    vec_t        vecs[11];
    int          total = 0;
    int          bad = 0;
    int          en_cnt = 0;
    bit          m_last_b;
    logic [15:0] m_rd_a, m_rd_b;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (h_en) en_cnt++;
        if (a_ack || b_ack) begin
            if (sb.size() == 0) begin
                chk("unexpected_ack", {30'd0, a_ack, b_ack}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("ack_port", {30'd0, a_ack, b_ack}, e.port_b ? 32'd1 : 32'd2);
                chk("err", {31'd0, err}, {31'd0, e.err});
                chk("a_rd_data", {16'd0, a_rd_data}, {16'd0, e.ra});
                chk("b_rd_data", {16'd0, b_rd_data}, {16'd0, e.rb});
            end
        end else if (err) begin
            chk("err_without_ack", {31'd0, err}, 32'd0);
        end
    end

    task automatic run_vec(input vec_t v);
        bit          aw, wr, got;
        int          en0, tgt;
        exp_t        e;
        a_req = v.a_req; b_req = v.b_req; a_wr = v.a_wr; b_wr = v.b_wr;
        a_addr = v.a_addr; b_addr = v.b_addr; a_wr_data = v.a_wd; b_wr_data = v.b_wd;
        h_data_rd = v.rd;
        #1;
        chk("h_idle_req", {31'd0, h_idle}, {31'd0, !(v.a_req || v.b_req)});
`ifdef SDRAM_ARB_APRIO_EN
        aw = v.a_req;
`else
        aw = v.a_req && (!v.b_req || m_last_b);
`endif
        wr  = aw ? v.a_wr : v.b_wr;
        en0 = en_cnt;
        @(posedge clk); #1;
        chk("h_en_issue", {31'd0, h_en}, 32'd1);
        chk("h_addr", {9'd0, h_addr}, {9'd0, aw ? v.a_addr : v.b_addr});
        chk("h_wr_data", {16'd0, h_wr_data}, {16'd0, aw ? v.a_wd : v.b_wd});
        chk("h_rd_wr", {30'd0, h_rd, h_wr}, wr ? 32'd1 : 32'd2);
        if (!wr) begin
            if (aw) m_rd_a = (v.dly < 0) ? 16'hFFFF : v.rd;
            else    m_rd_b = (v.dly < 0) ? 16'hFFFF : v.rd;
        end
        e.port_b = !aw;
        e.err    = (v.dly < 0);
        e.ra     = m_rd_a;
        e.rb     = m_rd_b;
        sb.push_back(e);
        m_last_b = !aw;
        tgt = (v.dly < 0) ? T : v.dly + 1;
        @(posedge clk); #1;
        got = 0;
        for (int k = 1; k <= T + 5 && !got; k++) begin
            h_done = (k == v.dly + 1);
            @(posedge clk); #1;
            h_done = 1'b0;
            if (a_ack || b_ack) begin
                got = 1;
                chk("ack_latency", k, tgt);
            end
        end
        if (!got) chk("ack_missing", 32'd0, 32'd1);
        chk("h_en_pulses", en_cnt - en0, 32'd1);
    endtask

    initial begin
        vecs[0]  = '{1, 1, 0, 0, 23'h000011, 23'h000022, 16'h0, 16'h0, 0, 16'h1111};
        vecs[1]  = '{1, 1, 0, 0, 23'h000011, 23'h000022, 16'h0, 16'h0, 1, 16'h2222};
        vecs[2]  = '{1, 1, 0, 0, 23'h000033, 23'h000044, 16'h0, 16'h0, 0, 16'h3333};
        vecs[3]  = '{1, 1, 0, 0, 23'h000033, 23'h000044, 16'h0, 16'h0, 2, 16'h4444};
        vecs[4]  = '{1, 0, 0, 0, 23'h000123, 23'h000000, 16'h0, 16'h0, 1, 16'hBEEF};
        vecs[5]  = '{0, 1, 0, 1, 23'h000000, 23'h000456, 16'h0, 16'h5A5A, 1, 16'h9999};
        vecs[6]  = '{1, 0, 0, 0, 23'h000777, 23'h000000, 16'h0, 16'h0, -1, 16'h6666};
        vecs[7]  = '{1, 0, 0, 0, 23'h000888, 23'h000000, 16'h0, 16'h0, 0, 16'h1234};
        vecs[8]  = '{1, 1, 1, 0, 23'h00009A, 23'h00000B, 16'hC0DE, 16'h0, 0, 16'h7777};
        vecs[9]  = '{0, 1, 0, 0, 23'h000000, 23'h2AAAAA, 16'h0, 16'h0, 3, 16'hCAFE};
        vecs[10] = '{1, 0, 1, 0, 23'h7FFFFF, 23'h000000, 16'hA5A5, 16'h0, 0, 16'h0F0F};

        rst_n = 1'b0;
        a_req = 0; b_req = 0; a_wr = 0; b_wr = 0; a_addr = '0; b_addr = '0;
        a_wr_data = '0; b_wr_data = '0; h_data_rd = '0; h_done = 0;
        m_last_b = 1'b1; m_rd_a = '0; m_rd_b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_strobes", {27'd0, h_en, h_rd, h_wr, a_ack, b_ack}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_h_addr", {9'd0, h_addr}, 32'd0);
        chk("rst_h_wr_data", {16'd0, h_wr_data}, 32'd0);
        chk("rst_rd_data", {a_rd_data, b_rd_data}, 32'd0);
        chk("rst_h_idle", {31'd0, h_idle}, 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++) run_vec(vecs[i]);
        a_req = 0; b_req = 0;
        #1;
        chk("h_idle_after", {31'd0, h_idle}, 32'd1);

        // Reset in the middle of WAIT, then a late HDone: no Ack may appear.
        a_req = 1; a_wr = 0; a_addr = 23'h000055; h_data_rd = 16'hDEAD;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b0;
        a_req = 0;
        #1;
        chk("midrst_strobes", {27'd0, h_en, h_rd, h_wr, a_ack, b_ack}, 32'd0);
        chk("midrst_h_addr", {9'd0, h_addr}, 32'd0);
        chk("midrst_h_wr_data", {16'd0, h_wr_data}, 32'd0);
        chk("midrst_rd_data", {a_rd_data, b_rd_data}, 32'd0);
        h_done = 1'b1;
        @(posedge clk); #1;
        h_done = 1'b0;
        rst_n = 1'b1;
        chk("midrst_h_idle", {31'd0, h_idle}, 32'd1);
        m_last_b = 1'b1; m_rd_a = '0; m_rd_b = '0;

        // Stray HDone while idle must be ignored.
        h_done = 1'b1;
        @(posedge clk); #1;
        h_done = 1'b0;
        chk("stray_done_ack", {29'd0, a_ack, b_ack, h_en}, 32'd0);
        @(posedge clk); #1;
        chk("stray_done_idle", {31'd0, h_idle}, 32'd1);

        // Last returns to B after reset, so the first tie goes to A again.
        run_vec(vecs[0]);
        run_vec(vecs[1]);
        a_req = 0; b_req = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
